// File: rtl/param_fifo_buffer.sv
// Parametrised single-clock FIFO: arbitrary depth with explicit pointer wrap,
// selectable first-word fall-through or registered head, threshold and sticky error flags.
module param_fifo_buffer #(
  parameter int unsigned BUFFER_WIDTH    = 8,
  parameter int unsigned BUFFER_DEPTH    = 16,
  parameter bit          FWFT            = 1'b1,
  parameter int unsigned ALMOST_FULL_TH  = BUFFER_DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY_TH = 2,
  parameter int unsigned CW              = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pull,
  input  logic                    flush,
  input  logic [BUFFER_WIDTH-1:0] tail,
  output logic [BUFFER_WIDTH-1:0] head,
  output logic                    head_valid,
  output logic [CW-1:0]           counter,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned PW       = $clog2(BUFFER_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUFFER_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_DEPTH);

  logic [BUFFER_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [CW-1:0]           cnt_q;
  logic [BUFFER_WIDTH-1:0] head_q;
  logic                    head_valid_q;
  logic                    overflow_q;
  logic                    underflow_q;
  logic                    push_ok;
  logic                    pull_ok;

  // Wrap at the last physical slot rather than relying on power-of-two rollover.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full         = (cnt_q == FULL_CNT);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (32'(cnt_q) >= ALMOST_FULL_TH);
  assign almost_empty = (32'(cnt_q) <= ALMOST_EMPTY_TH);
  assign counter      = cnt_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A pull frees a slot in the same edge, so a full FIFO still takes a paired push.
  assign pull_ok = pull & ~empty;
  assign push_ok = push & (~full | pull_ok);

  // Storage is not reset; pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (!flush && push_ok) begin
      mem[wr_ptr_q] <= tail;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      head_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pull_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        head_q   <= mem[rd_ptr_q];
      end
      head_valid_q <= pull_ok;
      case ({push_ok, pull_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
      if (pull && !pull_ok) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Fall-through head reads the array directly; it is forced to zero while nothing is stored.
  assign head       = FWFT ? (empty ? '0 : mem[rd_ptr_q]) : head_q;
  assign head_valid = FWFT ? ~empty : head_valid_q;

endmodule

// File: tb/tb_param_fifo_buffer.sv
// Directed bench for param_fifo_buffer: depth-5 fall-through instance and depth-5 registered-head instance.
module tb_param_fifo_buffer;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 5;
  localparam int unsigned CW = $clog2(D + 1);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          a_reset, a_push, a_pull, a_flush;
  logic [W-1:0]  a_tail, a_head;
  logic          a_head_valid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
  logic [CW-1:0] a_counter;

  logic          b_reset, b_push, b_pull, b_flush;
  logic [W-1:0]  b_tail, b_head;
  logic          b_head_valid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
  logic [CW-1:0] b_counter;

  int checks = 0;
  int errors = 0;

  param_fifo_buffer #(.BUFFER_WIDTH(W), .BUFFER_DEPTH(D), .FWFT(1'b1)) dut_a (
    .clock(clock), .reset(a_reset), .push(a_push), .pull(a_pull), .flush(a_flush),
    .tail(a_tail), .head(a_head), .head_valid(a_head_valid), .counter(a_counter),
    .full(a_full), .empty(a_empty), .almost_full(a_afull), .almost_empty(a_aempty),
    .overflow(a_ovf), .underflow(a_unf)
  );

  param_fifo_buffer #(.BUFFER_WIDTH(W), .BUFFER_DEPTH(D), .FWFT(1'b0)) dut_b (
    .clock(clock), .reset(b_reset), .push(b_push), .pull(b_pull), .flush(b_flush),
    .tail(b_tail), .head(b_head), .head_valid(b_head_valid), .counter(b_counter),
    .full(b_full), .empty(b_empty), .almost_full(b_afull), .almost_empty(b_aempty),
    .overflow(b_ovf), .underflow(b_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    a_reset = 1'b0; a_push = 1'b0; a_pull = 1'b0; a_flush = 1'b0; a_tail = '0;
    b_reset = 1'b0; b_push = 1'b0; b_pull = 1'b0; b_flush = 1'b0; b_tail = '0;
    #2;
    check("rst_counter", 32'(a_counter), 32'd0);
    check("rst_empty", 32'(a_empty), 32'd1);
    check("rst_full", 32'(a_full), 32'd0);
    check("rst_aempty", 32'(a_aempty), 32'd1);
    check("rst_afull", 32'(a_afull), 32'd0);
    check("rst_head", 32'(a_head), 32'd0);
    check("rst_hvalid", 32'(a_head_valid), 32'd0);
    check("rst_ovf", 32'(a_ovf), 32'd0);
    check("rst_unf", 32'(a_unf), 32'd0);
    check("rst_b_head", 32'(b_head), 32'd0);
    step();
    step();
    a_reset = 1'b1;

    // Fill to full.
    for (int i = 0; i < 5; i++) begin
      a_push = 1'b1;
      a_tail = W'(8'h11 * (i + 1));
      step();
      check("fill_counter", 32'(a_counter), 32'(i + 1));
      check("fill_head", 32'(a_head), 32'h11);
      check("fill_afull", 32'(a_afull), 32'((i + 1) >= 3));
      check("fill_full", 32'(a_full), 32'(i == 4));
    end
    a_push = 1'b1; a_tail = 8'h66;
    step();
    a_push = 1'b0;
    check("ovf_set", 32'(a_ovf), 32'd1);
    check("ovf_counter", 32'(a_counter), 32'd5);
    check("ovf_head", 32'(a_head), 32'h11);

    // Drain in order.
    for (int i = 0; i < 5; i++) begin
      check("drain_head", 32'(a_head), 32'(8'h11 * (i + 1)));
      a_pull = 1'b1;
      step();
    end
    a_pull = 1'b0;
    check("drain_empty", 32'(a_empty), 32'd1);
    check("drain_ovf_sticky", 32'(a_ovf), 32'd1);
    check("drain_unf", 32'(a_unf), 32'd0);

    // Hold occupancy at 2 while both pointers wrap.
    for (int i = 0; i < 2; i++) begin
      a_push = 1'b1; a_tail = W'(8'h80 + i);
      step();
    end
    for (int i = 0; i < 12; i++) begin
      check("wrap_head", 32'(a_head), 32'(8'h80 + i));
      a_push = 1'b1; a_pull = 1'b1; a_tail = W'(8'h82 + i);
      step();
      check("wrap_counter", 32'(a_counter), 32'd2);
    end
    a_push = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("wrap_tail_head", 32'(a_head), 32'(8'h8C + i));
      a_pull = 1'b1;
      step();
    end
    a_pull = 1'b0;
    check("wrap_empty", 32'(a_empty), 32'd1);
    check("wrap_unf", 32'(a_unf), 32'd0);

    // Push and pull together while empty.
    a_push = 1'b1; a_pull = 1'b1; a_tail = 8'hA5;
    step();
    a_pull = 1'b0;
    check("pe_counter", 32'(a_counter), 32'd1);
    check("pe_head", 32'(a_head), 32'hA5);
    check("pe_unf", 32'(a_unf), 32'd1);
    check("pe_hvalid", 32'(a_head_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      a_tail = W'(8'hB1 + i);
      step();
    end
    check("pf_full", 32'(a_full), 32'd1);

    // Push and pull together while full: oldest returned, count unchanged.
    check("pf_oldest", 32'(a_head), 32'hA5);
    a_pull = 1'b1; a_tail = 8'hC0;
    step();
    a_push = 1'b0; a_pull = 1'b0;
    check("pf_counter", 32'(a_counter), 32'd5);
    check("pf_full_hold", 32'(a_full), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("pf_order", 32'(a_head), (i == 4) ? 32'hC0 : 32'(8'hB1 + i));
      a_pull = 1'b1;
      step();
    end
    a_pull = 1'b0;

    // Flush with three entries and overflow pending; the same-cycle push is ignored.
    for (int i = 0; i < 3; i++) begin
      a_push = 1'b1; a_tail = W'(8'hD1 + i);
      step();
    end
    check("fl_pre_counter", 32'(a_counter), 32'd3);
    check("fl_pre_ovf", 32'(a_ovf), 32'd1);
    a_flush = 1'b1; a_tail = 8'hEE;
    step();
    a_flush = 1'b0; a_push = 1'b0;
    check("fl_counter", 32'(a_counter), 32'd0);
    check("fl_empty", 32'(a_empty), 32'd1);
    check("fl_ovf", 32'(a_ovf), 32'd0);
    check("fl_unf", 32'(a_unf), 32'd0);
    check("fl_hvalid", 32'(a_head_valid), 32'd0);

    // Asynchronous reset between edges.
    for (int i = 0; i < 2; i++) begin
      a_push = 1'b1; a_tail = W'(8'h71 + i);
      step();
    end
    a_push = 1'b0;
    check("ar_pre_counter", 32'(a_counter), 32'd2);
    #3;
    a_reset = 1'b0;
    #1;
    check("ar_counter", 32'(a_counter), 32'd0);
    check("ar_empty", 32'(a_empty), 32'd1);
    check("ar_aempty", 32'(a_aempty), 32'd1);
    check("ar_head", 32'(a_head), 32'd0);
    check("ar_hvalid", 32'(a_head_valid), 32'd0);
    step();
    a_reset = 1'b1; a_push = 1'b1; a_tail = 8'h5A;
    step();
    a_push = 1'b0;
    check("ar_first_push", 32'(a_counter), 32'd1);
    check("ar_first_head", 32'(a_head), 32'h5A);

    // Registered-head instance.
    b_reset = 1'b1;
    b_push = 1'b1; b_tail = 8'h10;
    step();
    b_tail = 8'h20;
    step();
    b_push = 1'b0;
    check("rh_counter", 32'(b_counter), 32'd2);
    check("rh_hvalid_idle", 32'(b_head_valid), 32'd0);
    check("rh_head_idle", 32'(b_head), 32'd0);
    b_pull = 1'b1;
    step();
    b_pull = 1'b0;
    check("rh_head", 32'(b_head), 32'h10);
    check("rh_hvalid", 32'(b_head_valid), 32'd1);
    check("rh_counter1", 32'(b_counter), 32'd1);
    step();
    check("rh_hvalid_drop", 32'(b_head_valid), 32'd0);
    check("rh_head_hold", 32'(b_head), 32'h10);
    b_pull = 1'b1;
    step();
    check("rh_head2", 32'(b_head), 32'h20);
    check("rh_hvalid2", 32'(b_head_valid), 32'd1);
    step();
    b_pull = 1'b0;
    check("rh_unf", 32'(b_unf), 32'd1);
    check("rh_hvalid_unf", 32'(b_head_valid), 32'd0);
    check("rh_head_unf", 32'(b_head), 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
